// File: rtl/reg_file_banked.sv
// Banked CPU register file: SFRs, GPR RAM, INDF/FSR indirection and TMR0 with prescaler.
// Optional macro REG_FILE_PORT_SYNC_EN adds 2-flop synchronisers on the port pin inputs.
module reg_file_banked #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned BANKS   = 2,
  parameter int unsigned PORTA_W = 4,
  parameter int unsigned PORTB_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               f_wr,
  input  logic [ADDR_W-1:0]  f_adrs,
  input  logic [DATA_W-1:0]  f_in_data,
  output logic [DATA_W-1:0]  f_out_data,
  input  logic               C_en,
  input  logic               DC_en,
  input  logic               Z_en,
  input  logic               C_new,
  input  logic               DC_new,
  input  logic               Z_new,
  input  logic               SLEEP,
  input  logic               CLRWDT,
  input  logic               wdtmr,
  input  logic               tmr0_inc,
  input  logic [DATA_W-1:0]  PCL1,
  output logic               PCL_wr,
  input  logic [PORTA_W-1:0] porta_in,
  input  logic [PORTB_W-1:0] portb_in,
  output logic [PORTA_W-1:0] PORTA,
  output logic [PORTB_W-1:0] PORTB,
  output logic [PORTA_W-1:0] TRISA,
  output logic [PORTB_W-1:0] TRISB,
  output logic [DATA_W-1:0]  FSR,
  output logic               C,
  output logic               tmr0_ovf
);

  localparam int unsigned BANK_W = $clog2(BANKS);
  localparam int unsigned EA_W   = ADDR_W + BANK_W;

  logic [DATA_W-1:0]  tmr0_q, tmr0_d, option_q, option_d, fsr_q, fsr_d;
  logic [7:0]         presc_q, presc_d;
  logic [1:0]         inhib_q, inhib_d;
  logic               ovf_q, ovf_d;
  logic [PORTA_W-1:0] porta_q, porta_d, trisa_q, trisa_d;
  logic [PORTB_W-1:0] portb_q, portb_d, trisb_q, trisb_d;
  logic [2:0]         pa_q, pa_d;
  logic               to_n_q, to_n_d, pd_n_q, pd_n_d;
  logic               z_q, z_d, dc_q, dc_d, c_q, c_d;
  logic [DATA_W-1:0]  gpr_q [2**EA_W];

  logic [PORTA_W-1:0] pa_pins;
  logic [PORTB_W-1:0] pb_pins;

`ifdef REG_FILE_PORT_SYNC_EN
  logic [PORTA_W-1:0] pa_s1_q, pa_s2_q;
  logic [PORTB_W-1:0] pb_s1_q, pb_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pa_s1_q <= '0;
      pa_s2_q <= '0;
      pb_s1_q <= '0;
      pb_s2_q <= '0;
    end else begin
      pa_s1_q <= porta_in;
      pa_s2_q <= pa_s1_q;
      pb_s1_q <= portb_in;
      pb_s2_q <= pb_s1_q;
    end
  end

  assign pa_pins = pa_s2_q;
  assign pb_pins = pb_s2_q;
`else
  assign pa_pins = porta_in;
  assign pb_pins = portb_in;
`endif

  // Address decode: INDF (direct offset 0) redirects through FSR.
  logic [BANK_W-1:0] rp;
  logic              is_indf, odd_bank, wr_en;
  logic [EA_W-1:0]   ea;
  logic [ADDR_W-1:0] off;
  logic              wr_tmr0, wr_option, wr_status, wr_fsr;
  logic              wr_porta, wr_trisa, wr_portb, wr_trisb, wr_gpr;

  assign rp       = pa_q[BANK_W-1:0];
  assign is_indf  = (f_adrs == '0);
  assign ea       = is_indf ? fsr_q[EA_W-1:0] : {rp, f_adrs};
  assign off      = ea[ADDR_W-1:0];
  assign odd_bank = ea[ADDR_W];
  assign wr_en    = f_wr && (off != '0);

  assign wr_tmr0   = wr_en && (off == ADDR_W'(1)) && !odd_bank;
  assign wr_option = wr_en && (off == ADDR_W'(1)) &&  odd_bank;
  assign wr_status = wr_en && (off == ADDR_W'(3));
  assign wr_fsr    = wr_en && (off == ADDR_W'(4));
  assign wr_porta  = wr_en && (off == ADDR_W'(5)) && !odd_bank;
  assign wr_trisa  = wr_en && (off == ADDR_W'(5)) &&  odd_bank;
  assign wr_portb  = wr_en && (off == ADDR_W'(6)) && !odd_bank;
  assign wr_trisb  = wr_en && (off == ADDR_W'(6)) &&  odd_bank;
  assign wr_gpr    = wr_en && (off >= ADDR_W'(7));

  assign PCL_wr = f_wr && (off == ADDR_W'(2));

  logic [7:0] status;
  assign status = {pa_q, to_n_q, pd_n_q, z_q, dc_q, c_q};

  always_comb begin
    f_out_data = '0;
    case (off)
      ADDR_W'(0): f_out_data = '0;
      ADDR_W'(1): f_out_data = odd_bank ? option_q : tmr0_q;
      ADDR_W'(2): f_out_data = PCL1;
      ADDR_W'(3): f_out_data = DATA_W'(status);
      ADDR_W'(4): f_out_data = fsr_q;
      ADDR_W'(5): f_out_data = odd_bank ? DATA_W'(trisa_q) : DATA_W'(pa_pins);
      ADDR_W'(6): f_out_data = odd_bank ? DATA_W'(trisb_q) : DATA_W'(pb_pins);
      default:    f_out_data = gpr_q[ea];
    endcase
  end

  // TMR0: prescaler tap mask M = 2^(PS+1)-1; writes clear prescaler and hold off two ticks.
  logic       psa, tick;
  logic [7:0] ps_mask;

  assign psa     = option_q[3];
  assign ps_mask = 8'hFF >> (3'd7 - option_q[2:0]);

  always_comb begin
    tmr0_d  = tmr0_q;
    presc_d = presc_q;
    inhib_d = (inhib_q != 2'd0) ? inhib_q - 2'd1 : 2'd0;
    ovf_d   = 1'b0;
    tick    = 1'b0;
    if (wr_tmr0) begin
      tmr0_d  = f_in_data;
      presc_d = '0;
      inhib_d = 2'd2;
    end else if (tmr0_inc && (inhib_q == 2'd0)) begin
      if (psa) begin
        tick = 1'b1;
      end else begin
        presc_d = presc_q + 8'd1;
        tick    = ((presc_q & ps_mask) == ps_mask);
      end
      if (tick) begin
        tmr0_d = tmr0_q + DATA_W'(1);
        ovf_d  = (tmr0_q == '1);
      end
    end
  end

  always_comb begin
    option_d = wr_option ? f_in_data : option_q;
    fsr_d    = wr_fsr    ? f_in_data : fsr_q;
    porta_d  = wr_porta  ? f_in_data[PORTA_W-1:0] : porta_q;
    trisa_d  = wr_trisa  ? f_in_data[PORTA_W-1:0] : trisa_q;
    portb_d  = wr_portb  ? f_in_data[PORTB_W-1:0] : portb_q;
    trisb_d  = wr_trisb  ? f_in_data[PORTB_W-1:0] : trisb_q;
    pa_d     = wr_status ? f_in_data[7:5] : pa_q;
    z_d      = z_q;
    dc_d     = dc_q;
    c_d      = c_q;
    // ALU flag updates take precedence over a software STATUS write.
    if (C_en || DC_en || Z_en) begin
      if (Z_en)  z_d  = Z_new;
      if (DC_en) dc_d = DC_new;
      if (C_en)  c_d  = C_new;
    end else if (wr_status) begin
      z_d  = f_in_data[2];
      dc_d = f_in_data[1];
      c_d  = f_in_data[0];
    end
    to_n_d = to_n_q;
    pd_n_d = pd_n_q;
    if (CLRWDT) begin
      to_n_d = 1'b1;
      pd_n_d = 1'b1;
    end
    if (SLEEP) begin
      to_n_d = 1'b1;
      pd_n_d = 1'b0;
    end
    if (wdtmr) to_n_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr0_q   <= '0;
      presc_q  <= '0;
      inhib_q  <= 2'd0;
      ovf_q    <= 1'b0;
      option_q <= '1;
      fsr_q    <= '0;
      porta_q  <= '0;
      portb_q  <= '0;
      trisa_q  <= '1;
      trisb_q  <= '1;
      pa_q     <= 3'd0;
      to_n_q   <= 1'b1;
      pd_n_q   <= 1'b1;
      z_q      <= 1'b0;
      dc_q     <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      tmr0_q   <= tmr0_d;
      presc_q  <= presc_d;
      inhib_q  <= inhib_d;
      ovf_q    <= ovf_d;
      option_q <= option_d;
      fsr_q    <= fsr_d;
      porta_q  <= porta_d;
      portb_q  <= portb_d;
      trisa_q  <= trisa_d;
      trisb_q  <= trisb_d;
      pa_q     <= pa_d;
      to_n_q   <= to_n_d;
      pd_n_q   <= pd_n_d;
      z_q      <= z_d;
      dc_q     <= dc_d;
      c_q      <= c_d;
    end
  end

  // GPR RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_gpr) gpr_q[ea] <= f_in_data;
  end

  assign PORTA    = porta_q;
  assign PORTB    = portb_q;
  assign TRISA    = trisa_q;
  assign TRISB    = trisb_q;
  assign FSR      = fsr_q;
  assign C        = c_q;
  assign tmr0_ovf = ovf_q;

endmodule

// File: tb/tb_reg_file_banked.sv
// Directed self-checking bench for reg_file_banked (default parameters, sync feature off).
module tb_reg_file_banked;

  logic       clk = 1'b0;
  logic       rst, f_wr;
  logic [4:0] f_adrs;
  logic [7:0] f_in_data, f_out_data;
  logic       C_en, DC_en, Z_en, C_new, DC_new, Z_new;
  logic       SLEEP, CLRWDT, wdtmr, tmr0_inc;
  logic [7:0] PCL1;
  logic       PCL_wr;
  logic [3:0] porta_in, PORTA, TRISA;
  logic [7:0] portb_in, PORTB, TRISB, FSR;
  logic       C, tmr0_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  reg_file_banked dut (
    .clk(clk), .rst(rst), .f_wr(f_wr), .f_adrs(f_adrs), .f_in_data(f_in_data),
    .f_out_data(f_out_data), .C_en(C_en), .DC_en(DC_en), .Z_en(Z_en), .C_new(C_new),
    .DC_new(DC_new), .Z_new(Z_new), .SLEEP(SLEEP), .CLRWDT(CLRWDT), .wdtmr(wdtmr),
    .tmr0_inc(tmr0_inc), .PCL1(PCL1), .PCL_wr(PCL_wr), .porta_in(porta_in),
    .portb_in(portb_in), .PORTA(PORTA), .PORTB(PORTB), .TRISA(TRISA), .TRISB(TRISB),
    .FSR(FSR), .C(C), .tmr0_ovf(tmr0_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    f_adrs    = a;
    f_in_data = d;
    f_wr      = 1'b1;
    step();
    f_wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
    f_adrs = a;
    #1;
    check_eq(tag, f_out_data, exp);
    step();
  endtask

  task automatic ticks(input int n);
    tmr0_inc = 1'b1;
    repeat (n) step();
    tmr0_inc = 1'b0;
  endtask

  initial begin
    rst = 1'b1; f_wr = 1'b0; f_adrs = '0; f_in_data = '0;
    C_en = 0; DC_en = 0; Z_en = 0; C_new = 0; DC_new = 0; Z_new = 0;
    SLEEP = 0; CLRWDT = 0; wdtmr = 0; tmr0_inc = 0;
    PCL1 = 8'h9C; porta_in = 4'h0; portb_in = 8'h00;
    repeat (2) step();
    rst = 1'b0;

    // Reset state
    rd_chk("status_rst", 5'h03, 8'h18);
    rd_chk("tmr0_rst", 5'h01, 8'h00);
    rd_chk("portb_pins0", 5'h06, 8'h00);
    check_eq("fsr_rst", FSR, 8'h00);
    check_eq("trisa_rst", 8'(TRISA), 8'h0F);
    check_eq("portb_rst", PORTB, 8'h00);
    check_eq("ovf_rst", 8'(tmr0_ovf), 8'h00);
    wr(5'h03, 8'h20);
    rd_chk("option_rst", 5'h01, 8'hFF);
    rd_chk("trisb_rst", 5'h06, 8'hFF);
    wr(5'h03, 8'h00);
    portb_in = 8'hA5; porta_in = 4'h6;
    rd_chk("portb_pins", 5'h06, 8'hA5);
    rd_chk("porta_pins", 5'h05, 8'h06);

    // Banked GPR
    wr(5'h03, 8'h20);
    wr(5'h10, 8'h55);
    wr(5'h03, 8'h00);
    wr(5'h10, 8'hAA);
    rd_chk("gpr_bank0", 5'h10, 8'hAA);
    wr(5'h03, 8'h20);
    rd_chk("gpr_bank1", 5'h10, 8'h55);
    wr(5'h03, 8'h00);

    // Indirect addressing
    wr(5'h04, 8'h30);
    check_eq("fsr_out", FSR, 8'h30);
    wr(5'h00, 8'h3C);
    rd_chk("indf_read", 5'h00, 8'h3C);
    wr(5'h03, 8'h20);
    rd_chk("indf_wr_bank1", 5'h10, 8'h3C);
    wr(5'h03, 8'h00);
    wr(5'h04, 8'h00);
    rd_chk("indf_self", 5'h00, 8'h00);
    wr(5'h00, 8'h77);
    rd_chk("indf_self_wr", 5'h03, 8'h18);

    // PCL
    rd_chk("pcl_read", 5'h02, 8'h9C);
    f_adrs = 5'h02; f_wr = 1'b1; #1;
    check_eq("pcl_wr_hi", 8'(PCL_wr), 8'h01);
    f_wr = 1'b0; #1;
    check_eq("pcl_wr_lo", 8'(PCL_wr), 8'h00);
    step();

    // Port latches and TRIS
    wr(5'h05, 8'hFA);
    check_eq("porta_latch", 8'(PORTA), 8'h0A);
    wr(5'h06, 8'h3C);
    check_eq("portb_latch", PORTB, 8'h3C);
    wr(5'h03, 8'h20);
    wr(5'h05, 8'h03);
    check_eq("trisa_out", 8'(TRISA), 8'h03);
    rd_chk("trisa_read", 5'h05, 8'h03);

    // TMR0 with 1:4 prescaler and write inhibit
    wr(5'h01, 8'h01);
    rd_chk("option_wr", 5'h01, 8'h01);
    wr(5'h03, 8'h00);
    wr(5'h01, 8'hFE);
    ticks(2);
    rd_chk("tmr0_inhibit", 5'h01, 8'hFE);
    ticks(7);
    rd_chk("tmr0_7", 5'h01, 8'hFF);
    check_eq("ovf_7", 8'(tmr0_ovf), 8'h00);
    ticks(1);
    check_eq("ovf_8", 8'(tmr0_ovf), 8'h01);
    rd_chk("tmr0_8", 5'h01, 8'h00);
    check_eq("ovf_after", 8'(tmr0_ovf), 8'h00);

    // Flag priority over STATUS write
    wr(5'h03, 8'h21);
    check_eq("c_set", 8'(C), 8'h01);
    Z_en = 1'b1; Z_new = 1'b1;
    wr(5'h03, 8'h00);
    Z_en = 1'b0; Z_new = 1'b0;
    rd_chk("flag_prio", 5'h03, 8'h1D);
    C_en = 1'b1; C_new = 1'b0;
    step();
    C_en = 1'b0;
    rd_chk("c_en_clr", 5'h03, 8'h1C);

    // Power / watchdog
    SLEEP = 1'b1; step(); SLEEP = 1'b0;
    rd_chk("sleep", 5'h03, 8'h14);
    wdtmr = 1'b1; step(); wdtmr = 1'b0;
    rd_chk("wdt", 5'h03, 8'h04);
    CLRWDT = 1'b1; step(); CLRWDT = 1'b0;
    rd_chk("clrwdt", 5'h03, 8'h1C);

    // Reset beats a concurrent write
    rst = 1'b1;
    wr(5'h04, 8'h55);
    rst = 1'b0;
    check_eq("rst_over_wr", FSR, 8'h00);
    rd_chk("rst_status", 5'h03, 8'h18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
